// File: rtl/fetch_stage.sv
// RV32 instruction fetch with a single-outstanding valid/ready memory port,
// a one-entry skid buffer for decode stalls, and the IF/ID pipeline register.
module fetch_stage #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = 32'h0000_0000,
  parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Stall,
  input  logic            Flush,
  input  logic            Redirect,
  input  logic [XLEN-1:0] RedirectPC,
  output logic            IMemReq,
  output logic [XLEN-1:0] IMemAddr,
  input  logic            IMemReady,
  input  logic [31:0]     IMemRData,
  output logic [31:0]     InstrD,
  output logic [6:0]      OpD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  localparam int unsigned ILEN = 32;
  localparam int unsigned OPW  = 7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pcf_q;
  logic              kill_q;
  logic [XLEN-1:0]   pend_pc_q;
  logic [ILEN-1:0]   buf_instr_q;
  logic [XLEN-1:0]   buf_pc_q;
  logic [ILEN-1:0]   instr_q;
  logic [XLEN-1:0]   pcd_q;
  logic [XLEN-1:0]   pcp4_q;
  logic              valid_q;

  logic [XLEN-1:0]   redirect_pc_c;
  logic              drop_c;
  logic              ld_mem_c;
  logic              ld_buf_c;
  logic              fill_buf_c;
  logic              kill_set_c;

  // Redirect targets are always word aligned
  assign redirect_pc_c = RedirectPC & ~(XLEN'(3));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (fill_buf_c) state_d = S_HOLD;
      S_HOLD:  if (Redirect || !Stall) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: request valid plus datapath strobes
  always_comb begin
    IMemReq    = 1'b0;
    drop_c     = 1'b0;
    ld_mem_c   = 1'b0;
    ld_buf_c   = 1'b0;
    fill_buf_c = 1'b0;
    kill_set_c = 1'b0;
    case (state_q)
      S_FETCH: begin
        IMemReq = 1'b1;
        if (IMemReady) begin
          if (kill_q || Redirect) drop_c     = 1'b1;
          else if (Stall)         fill_buf_c = 1'b1;
          else                    ld_mem_c   = 1'b1;
        end else if (Redirect) begin
          kill_set_c = 1'b1;
        end
      end
      S_HOLD:  if (!Redirect && !Stall) ld_buf_c = 1'b1;
      default: ;
    endcase
  end

  // Program counter and in-flight kill tracking; PCF is the request address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcf_q     <= RESET_PC;
      kill_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (Redirect) pcf_q <= redirect_pc_c;
        S_FETCH: begin
          if (drop_c) begin
            pcf_q  <= Redirect ? redirect_pc_c : pend_pc_q;
            kill_q <= 1'b0;
          end else if (fill_buf_c || ld_mem_c) begin
            pcf_q <= pcf_q + XLEN'(4);
          end else if (kill_set_c) begin
            kill_q    <= 1'b1;
            pend_pc_q <= redirect_pc_c;
          end
        end
        S_HOLD: if (Redirect) pcf_q <= redirect_pc_c;
        default: ;
      endcase
    end
  end

  // Skid buffer captures a response that arrives while decode is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
    end else if (fill_buf_c) begin
      buf_instr_q <= IMemRData;
      buf_pc_q    <= pcf_q;
    end
  end

  // IF/ID register: flush beats stall beats load; idle cycles insert a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_INSTR;
      pcd_q   <= '0;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
    end else if (Flush) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (Stall) begin
      instr_q <= instr_q;
    end else if (ld_mem_c) begin
      instr_q <= IMemRData;
      pcd_q   <= pcf_q;
      pcp4_q  <= pcf_q + XLEN'(4);
      valid_q <= 1'b1;
    end else if (ld_buf_c) begin
      instr_q <= buf_instr_q;
      pcd_q   <= buf_pc_q;
      pcp4_q  <= buf_pc_q + XLEN'(4);
      valid_q <= 1'b1;
    end else begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end
  end

  assign IMemAddr = pcf_q;
  assign InstrD   = instr_q;
  assign OpD      = instr_q[OPW-1:0];
  assign PCD      = pcd_q;
  assign PCPlus4D = pcp4_q;
  assign ValidD   = valid_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
RV32 instruction-fetch stage plus IF/ID pipeline register. It owns the program counter and issues single-outstanding requests on a valid/ready instruction-memory port. It holds one fetched instruction in a skid buffer while decode is stalled. It drives InstrD and OpD straight into the main decoder, and it handles redirects (branch/jump) and decode flushes, including discarding a response that is already in flight.

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h0000_0000, PCF value after reset
NOP_INSTR, 32'h0000_0013, InstrD value when the IF/ID slot is empty (addi x0,x0,0)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
Stall  in  1  freeze PCF and IF/ID (from hazard unit)
Flush  in  1  invalidate IF/ID slot
Redirect  in  1  taken branch/jump this cycle
RedirectPC  in  XLEN  redirect target; bits [1:0] ignored and forced to 0
IMemReq  out  1  request valid
IMemAddr  out  XLEN  request address, always word aligned
IMemReady  in  1  memory accepts the request; IMemRData is valid in the same cycle
IMemRData  in  32  fetched word
InstrD  out  32  IF/ID instruction
OpD  out  7  InstrD[6:0], combinational, feeds decoder Op
PCD  out  XLEN  PC of InstrD
PCPlus4D  out  XLEN  PCD+4
ValidD  out  1  IF/ID slot holds a real instruction

Behaviour:
- Reset (async, rst_n=0):
  - PCF=RESET_PC, state=IDLE, Kill=0, PendPC=0.
  - IMemReq=0, ValidD=0, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0.
- States:
  - IDLE: IMemReq=0; always goes to FETCH next cycle. A Redirect here loads PCF=RedirectPC.
  - FETCH: IMemReq=1, IMemAddr=PCF (or PendPC path below).
  - HOLD: IMemReq=0; the skid buffer (BufInstr, BufPC) is full.
- Handshake:
  - Once IMemReq=1, it and IMemAddr are held stable until the cycle IMemReady=1.
  - One request outstanding at a time. A zero-wait response (ready in the first request cycle) is legal.
  - Max throughput is one instruction per cycle.
- FETCH with IMemReady=1 and Kill=0 and Redirect=0:
  - Stall=0: InstrD=IMemRData, PCD=PCF, PCPlus4D=PCF+4, ValidD=1, PCF=PCF+4; stay in FETCH.
  - Stall=1: BufInstr=IMemRData, BufPC=PCF, PCF=PCF+4; go to HOLD. IF/ID is unchanged.
- FETCH with IMemReady=0 and Redirect=1: Kill=1, PendPC=RedirectPC. IMemAddr keeps the old PCF. A later Redirect overwrites PendPC.
- FETCH with IMemReady=1 and (Kill=1 or Redirect=1): the response is discarded. PCF=(Redirect ? RedirectPC : PendPC), Kill=0; stay in FETCH. The new address is issued next cycle.
- HOLD:
  - Stall=0: load IF/ID from the buffer (ValidD=1); go to FETCH.
  - Redirect=1: drop the buffer, PCF=RedirectPC; go to FETCH.
- IF/ID priority: Flush > Stall > load.
  - Flush forces ValidD=0 and InstrD=NOP_INSTR. PCD and PCPlus4D are don't-care.
  - Flush together with a buffer unload discards the buffered instruction.
- With Stall=1 and no load, IF/ID holds its value, including ValidD.
- PC arithmetic is modulo 2^XLEN: 32'hFFFF_FFFC+4 = 0. PCF[1:0] is always 0.
- Reset mid-request: IMemReq drops immediately (async). A late IMemReady after reset is ignored because state is IDLE.

Test Plan:
1. Reset release; memory ready every cycle returning addr^32'hA5A5_0000 -> IMemAddr = 0,4,8,… on consecutive cycles; InstrD/PCD track one cycle later; ValidD rises in the 3rd cycle after reset release (IDLE, FETCH, then IF/ID visible).
2. Memory with 3 wait states; Redirect to 0x100 in the 2nd wait cycle -> IMemAddr stays at the old PC until ready; the response is dropped (ValidD unchanged); the next IMemAddr is 0x100.
3. Stall asserted in the cycle the response for PC=0x20 arrives, held 4 cycles -> state HOLD, IMemReq=0, IF/ID frozen; one cycle after Stall drops, InstrD=word@0x20, PCD=0x20, and the next request is 0x24.
4. Flush plus Redirect to 0x40 while HOLD is full -> ValidD=0, InstrD=0x00000013, the buffer is dropped, and the next IMemAddr is 0x40.
5. Redirect to 0xFFFF_FFFC with a zero-wait memory -> next addresses are 0xFFFF_FFFC, then 0x0000_0000; PCPlus4D=0 for the first of these; a RedirectPC of 0x103 yields IMemAddr=0x100.
6. rst_n pulsed low while IMemReq=1 and Kill=1 -> IMemReq=0 asynchronously; after release the first request is to RESET_PC; a stale IMemReady in IDLE has no effect.
